// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 16-bit RISC CPU: opcode constants, the
// decoder's jump-select encodings, the fetch-stage state enum, the
// instruction width and the bit positions of the fixed instruction fields.
//
// Instruction format (INSTR_W = 16):
//   [15:12] op   [11:8] rd   [7:4] rs   [3:0] imm4   ([7:0] imm8)
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Instruction field bit positions
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 4;
  localparam int IMM4_MSB = 3;
  localparam int IMM4_LSB = 0;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;

  // Opcodes seen by the control decoder on ir[15:12]
  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] SUB  = 4'h1;
  localparam logic [3:0] AND  = 4'h2;
  localparam logic [3:0] OR   = 4'h3;
  localparam logic [3:0] XOR  = 4'h4;
  localparam logic [3:0] SHL  = 4'h5;
  localparam logic [3:0] SHR  = 4'h6;
  localparam logic [3:0] ADDI = 4'h7;
  localparam logic [3:0] LDI  = 4'h8;
  localparam logic [3:0] BEQ  = 4'h9;
  localparam logic [3:0] JI   = 4'hA;
  localparam logic [3:0] JR   = 4'hB;
  localparam logic [3:0] SEG  = 4'hC;
  localparam logic [3:0] LED  = 4'hD;
  localparam logic [3:0] NOP  = 4'hE;
  localparam logic [3:0] RDSW = 4'hF;

  // Jump select from the decoder; 2'b11 behaves as JIJR_IMM
  localparam logic [1:0] JIJR_NONE = 2'b00;
  localparam logic [1:0] JIJR_REG  = 2'b01;
  localparam logic [1:0] JIJR_IMM  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_EXEC  = 2'd3
  } fetch_state_t;

  // Two's-complement sign extension of the 4-bit branch offset
  function automatic logic [15:0] sext_imm4(input logic [3:0] imm4);
    return {{12{imm4[3]}}, imm4};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux
// Purely combinational next-PC selection for the fetch stage.
// Priority (highest first): jump-immediate (jijr_op[1]), jump-register
// (jijr_op == JIJR_REG), taken branch-if-equal, sequential pc + 1.
// All arithmetic wraps modulo 2^PC_W. PC_W must lie in 4..16.
//
// Ports:
//   pc       in   PC_W  current program counter
//   imm8     in   8     ir[7:0]; imm4 is its low nibble
//   beq_op   in   1     branch-if-equal request
//   jijr_op  in   2     jump select
//   rd_data  in   16    register read of rd
//   rs_data  in   16    register read of rs (also the jump-register target)
//   next_pc  out  PC_W  selected next PC
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      imm8,
  input  logic            beq_op,
  input  logic [1:0]      jijr_op,
  input  logic [15:0]     rd_data,
  input  logic [15:0]     rs_data,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] imm_target;
  logic [PC_W-1:0] reg_target;
  logic            br_taken;

  // Size casts truncate/zero-extend; adding the truncated sign-extended
  // offset gives the correct modulo-2^PC_W result.
  assign seq_pc     = pc + PC_W'(1);
  assign br_target  = seq_pc + PC_W'(sext_imm4(imm8[3:0]));
  assign imm_target = PC_W'(imm8);
  assign reg_target = PC_W'(rs_data);
  assign br_taken   = beq_op && (rd_data == rs_data);

  always_comb begin
    next_pc = seq_pc;
    if (jijr_op[1]) begin
      next_pc = imm_target;
    end else if (jijr_op == JIJR_REG) begin
      next_pc = reg_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// PC / instruction-fetch stage. A four-state FSM (IDLE, FETCH, LATCH, EXEC)
// walks each instruction through three cycles: the ROM samples imem_addr in
// FETCH, ir captures imem_rdata at the end of LATCH, and at the end of EXEC
// pc takes the selected next PC and retire_cnt increments. exec_en is a
// registered decode of "state is EXEC" and gates all architectural writes.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   run          level, free-running execution (sampled in IDLE / EXEC exit)
//   step         one-cycle pulse, starts one instruction from IDLE
//   imem_addr    ROM address (= pc)
//   imem_rdata   ROM data, valid one cycle after address
//   ir           instruction register (ir[15:12] = opcode)
//   beq_op       branch-if-equal request (used only in EXEC)
//   jijr_op      jump select (used only in EXEC)
//   rd_data      register read of ir[11:8]
//   rs_data      register read of ir[7:4]
//   exec_en      one-cycle execute strobe
//   pc           current PC
//   halted       high while in IDLE
//   retire_cnt   wrapping count of executed instructions
module pc_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               beq_op,
  input  logic [1:0]         jijr_op,
  input  logic [15:0]        rd_data,
  input  logic [15:0]        rs_data,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [15:0]        retire_cnt
);

  import cpu_pkg::*;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            ld_ir;
  logic            ld_pc;
  logic [PC_W-1:0] next_pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; run is only looked at in IDLE and on EXEC exit,
  // step only in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (run || step) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: state_next = ST_EXEC;
      ST_EXEC:  state_next = run ? ST_FETCH : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    halted = (state == ST_IDLE);
    ld_ir  = (state == ST_LATCH);
    ld_pc  = (state == ST_EXEC);
  end

  // Registered so it is glitch-free for the write-enable ANDs downstream;
  // the async reset pulls it low immediately mid-instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_en <= 1'b0;
    end else begin
      exec_en <= (state_next == ST_EXEC);
    end
  end

  pc_next_mux #(
    .PC_W (PC_W)
  ) u_next (
    .pc      (pc),
    .imm8    (ir[IMM8_MSB:IMM8_LSB]),
    .beq_op  (beq_op),
    .jijr_op (jijr_op),
    .rd_data (rd_data),
    .rs_data (rs_data),
    .next_pc (next_pc)
  );

  // Datapath registers; ir holds from LATCH exit through EXEC so decoder
  // outputs and register reads are settled when pc is updated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      retire_cnt <= '0;
    end else begin
      if (ld_ir) ir <= imem_rdata;
      if (ld_pc) begin
        pc         <= next_pc;
        retire_cnt <= retire_cnt + 16'd1;
      end
    end
  end

  assign imem_addr = pc;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the 16-bit RISC CPU. It holds the PC, reads the synchronous instruction ROM, latches the instruction register whose opcode nibble drives the control decoder, and applies the decoder's branch and jump outputs to select the next PC. It also provides a one-cycle execute strobe that gates every architectural write (register file, 7-segment display, LEDs) and supports run and single-step operation.

## Interface
Parameters:
- PC_W, 8, PC and instruction-ROM address width
- INSTR_W, 16, instruction width (fixed format below)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = free-running execution
- step  in  1  single-cycle pulse (already synchronised); executes one instruction when halted
- imem_addr  out  PC_W  ROM address, equals pc
- imem_rdata  in  INSTR_W  ROM data, valid one cycle after address
- ir  out  INSTR_W  instruction register; ir[15:12] = opcode to control decoder
- beq_op  in  1  branch-if-equal request from decoder
- jijr_op  in  2  jump select from decoder: 00 none, 10 jump-immediate, 01 jump-register, 11 treated as jump-immediate
- rd_data  in  16  register-file read of ir[11:8]
- rs_data  in  16  register-file read of ir[7:4]
- exec_en  out  1  one-cycle strobe in EXEC; consumers AND it with write enables
- pc  out  PC_W  current PC
- halted  out  1  1 while in IDLE
- retire_cnt  out  16  count of executed instructions, wraps

## Operation
- Instruction fields: op = ir[15:12], rd = ir[11:8], rs = ir[7:4], imm4 = ir[3:0], imm8 = ir[7:0].
- FSM states: IDLE, FETCH, LATCH, EXEC.
  - IDLE -> FETCH when run = 1 or step = 1. Otherwise stay in IDLE.
  - FETCH -> LATCH unconditionally. The ROM samples imem_addr in this cycle.
  - LATCH -> EXEC unconditionally. ir <= imem_rdata at the end of this cycle.
  - EXEC -> FETCH if run = 1, else -> IDLE. pc <= next_pc at the end of this cycle, and retire_cnt increments.
- next_pc priority, highest first:
  1. jijr_op[1] = 1 -> imm8[PC_W-1:0], zero-extended if PC_W > 8.
  2. jijr_op = 01 -> rs_data[PC_W-1:0].
  3. beq_op = 1 and rd_data == rs_data -> pc + 1 + sign-extended imm4.
  4. Otherwise -> pc + 1.
- All PC arithmetic is modulo 2^PC_W: 0xFF + 1 -> 0x00, and 0x01 + 1 + (-4) -> 0xFE.
- beq_op and jijr_op are sampled only in EXEC. Values driven in other states are ignored, including X.
- run is sampled only in IDLE and at the EXEC exit. Deasserting run mid-instruction completes the current instruction, then the FSM halts.
- step is ignored outside IDLE. step with run = 0 executes exactly one instruction.

## Timing
- Every instruction takes 3 cycles: FETCH, LATCH, EXEC. With run held at 1 this gives one retire per 3 cycles.
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, ir = 0, state = IDLE, exec_en = 0, halted = 1, retire_cnt = 0.
- After reset release with run = 1, the first FETCH occurs on the first clock edge.
- exec_en is a registered decode of state. It is high for exactly one cycle per instruction and is never high in IDLE, FETCH or LATCH.
- ir is stable from the LATCH exit through the whole EXEC cycle, so decoder outputs and register reads settle within EXEC.
- rst asserted mid-instruction aborts the instruction immediately: no PC update, no retire increment, and exec_en = 0 asynchronously.

## Structure
- Shared package cpu_pkg holds:
  - the opcode constants (ADD = 4'h0 through RDSW = 4'hF)
  - JIJR_NONE, JIJR_REG and JIJR_IMM encodings
  - the fetch-state enum
  - INSTR_W and the instruction field bit positions
- One sub-module, pc_next_mux: purely combinational next-PC selection (priority, sign extension, wrap).
- The FSM, pc, ir and retire_cnt registers live in pc_fetch_unit.

## Test plan
- Reset then run = 1, ROM[0..2] = ADD: imem_addr sequence 0, 1, 2 every 3 cycles; exec_en pulses 3 cycles apart; retire_cnt = 3 after 9 cycles.
- Branch taken: pc = 0x10, beq_op = 1, rd_data = rs_data = 0x1234, imm4 = 4'hC -> pc becomes 0x0D. Same case with rd_data ≠ rs_data -> pc becomes 0x11.
- Jumps: jijr_op = 10 with imm8 = 0x42 -> pc becomes 0x42. jijr_op = 01 with rs_data = 0xBEEF -> pc becomes 0xEF. jijr_op = 10 with beq_op = X -> pc becomes imm8.
- Wrap: pc = 0xFF with no branch -> pc becomes 0x00. pc = 0x01, beq taken, imm4 = 4'hC -> pc becomes 0xFE.
- Single step: run = 0 with one step pulse -> exactly one exec_en, pc advances by 1, halted returns to 1. step pulses during FETCH or EXEC are ignored.
- Async reset asserted during EXEC -> exec_en drops the same cycle, pc = RESET_PC, retire_cnt not incremented.
